dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data-memory port.
// Owns the memory for one access at a time; it either completes on mem_ack or aborts after TIMEOUT cycles.
module dmem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    // Owner of the current access; outside ACCESS it is the last port granted.
    logic        owner_reg, owner_next;

    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  done_reg;
    logic [1:0]  err_reg;

    logic [1:0]  req_vec;
    logic [1:0]  we_vec;
    logic [31:0] addr_vec [2];
    logic [31:0] wdata_vec [2];
    logic [1:0]  gnt_vec;

    logic        grant_valid;
    logic        sel;
    logic        ack_evt;
    logic        timeout_evt;

    assign req_vec      = {req1, req0};
    assign we_vec       = {we1, we0};
    assign addr_vec[0]  = addr0;
    assign addr_vec[1]  = addr1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;

    // Reset also gates the grant so nothing is accepted while rst is held.
    assign grant_valid = (state_reg == IDLE) && (|req_vec) && !rst;
    // On a tie the port that did not own the memory last wins.
    assign sel         = (&req_vec) ? ~owner_reg : req_vec[1];

    assign ack_evt     = (state_reg == ACCESS) && mem_ack;
    assign timeout_evt = (state_reg == ACCESS) && !mem_ack && (cnt_reg == LIMIT);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign gnt_vec[gi] = grant_valid && (sel == 1'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    done_reg[gi] <= 1'b0;
                    err_reg[gi]  <= 1'b0;
                end else begin
                    done_reg[gi] <= ack_evt     && (owner_reg == 1'(gi));
                    err_reg[gi]  <= timeout_evt && (owner_reg == 1'(gi));
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ACCESS;
                    cnt_next   = 8'd0;
                    owner_next = sel;
                end
            end
            ACCESS: begin
                // Ack takes priority over the timeout when both land together.
                if (mem_ack || (cnt_reg == LIMIT)) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            owner_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            owner_reg <= owner_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
        end else if (grant_valid) begin
            mem_we_reg    <= we_vec[sel];
            mem_addr_reg  <= addr_vec[sel];
            mem_wdata_reg <= wdata_vec[sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg <= 32'd0;
        end else if (ack_evt && !mem_we_reg) begin
            rdata_reg <= mem_rdata;
        end
    end

    assign gnt0      = gnt_vec[0];
    assign gnt1      = gnt_vec[1];
    assign done0     = done_reg[0];
    assign done1     = done_reg[1];
    assign err0      = err_reg[0];
    assign err1      = err_reg[1];
    assign rdata     = rdata_reg;
    assign busy      = (state_reg == ACCESS);
    assign mem_req   = (state_reg == ACCESS);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, round-robin ties, read, write, timeout, ack-at-limit, reset mid-access.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] rdata;
    logic        busy, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    dmem_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata(rdata), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        int nreq, nerr, ndone, nerr1;

        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = 32'h0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20; wdata1 = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        // Reset state, with both requests already high
        sample();
        sample();
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_done0", done0, 1'b0);
        chk("rst_err0", err0, 1'b0);

        // Tie from reset: grant order 0,1,0,1 with one-cycle acks
        step();
        rst = 1'b0;
        sample();
        for (int k = 0; k < 4; k++) begin
            chk("tie_gnt0", gnt0, (k % 2 == 0));
            chk("tie_gnt1", gnt1, (k % 2 == 1));
            step();
            mem_ack = 1'b1;
            mem_rdata = 32'hA000_0000 + 32'(k);
            sample();
            chk("tie_mem_req", mem_req, 1'b1);
            chk("tie_mem_addr", mem_addr, (k % 2 == 1) ? 32'h20 : 32'h10);
            chk("tie_loser_gnt", gnt0 | gnt1, 1'b0);
            step();
            mem_ack = 1'b0;
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            sample();
            chk("tie_done0", done0, (k % 2 == 0));
            chk("tie_done1", done1, (k % 2 == 1));
            chk("tie_rdata", rdata, 32'hA000_0000 + 32'(k));
            $display("txn tie k=%0d gnt0=%0b done0=%0b done1=%0b rdata=%08h", k, (k % 2 == 0), done0, done1, rdata);
        end

        // mem_ack while idle has no effect
        step();
        mem_ack = 1'b1;
        mem_rdata = 32'h55;
        sample();
        chk("idleack_busy", busy, 1'b0);
        step();
        mem_ack = 1'b0;
        sample();
        chk("idleack_done", {done1, done0}, 2'b00);
        chk("idleack_rdata", rdata, 32'hA000_0003);
        $display("txn idle_ack rdata=%08h", rdata);

        // Read, ack on the third access cycle
        step();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
        sample();
        chk("rd_gnt0", gnt0, 1'b1);
        chk("rd_mem_req_T", mem_req, 1'b0);
        step();
        req0 = 1'b0;
        sample();
        chk("rd_mem_req_T1", mem_req, 1'b1);
        chk("rd_busy", busy, 1'b1);
        chk("rd_mem_addr", mem_addr, 32'h100);
        chk("rd_mem_we", mem_we, 1'b0);
        step();
        sample();
        chk("rd_mem_req_T2", mem_req, 1'b1);
        chk("rd_done_early", done0, 1'b0);
        step();
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        sample();
        chk("rd_mem_req_T3", mem_req, 1'b1);
        step();
        mem_ack = 1'b0;
        sample();
        chk("rd_done0", done0, 1'b1);
        chk("rd_err0", err0, 1'b0);
        chk("rd_busy_after", busy, 1'b0);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        step();
        sample();
        chk("rd_done0_pulse", done0, 1'b0);
        $display("txn read port0 addr=00000100 rdata=%08h", rdata);

        // Write on port 1
        step();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h12345678;
        sample();
        chk("wr_gnt1", gnt1, 1'b1);
        step();
        req1 = 1'b0;
        sample();
        chk("wr_mem_we", mem_we, 1'b1);
        chk("wr_mem_wdata", mem_wdata, 32'h12345678);
        chk("wr_mem_addr", mem_addr, 32'h40);
        step();
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        sample();
        chk("wr_mem_we2", mem_we, 1'b1);
        chk("wr_mem_wdata2", mem_wdata, 32'h12345678);
        step();
        mem_ack = 1'b0;
        sample();
        chk("wr_done1", done1, 1'b1);
        chk("wr_done0", done0, 1'b0);
        chk("wr_rdata", rdata, 32'hDEADBEEF);
        $display("txn write port1 addr=00000040 wdata=12345678 rdata=%08h", rdata);

        // Timeout: ack never comes
        step();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h200;
        sample();
        chk("to_gnt0", gnt0, 1'b1);
        step();
        req0 = 1'b0;
        nreq = 0; nerr = 0; ndone = 0; nerr1 = 0;
        for (int i = 0; i < 30; i++) begin
            sample();
            if (mem_req) nreq++;
            if (err0) nerr++;
            if (done0) ndone++;
            if (err1) nerr1++;
            step();
        end
        sample();
        chk("to_mem_req_cycles", nreq, 16);
        chk("to_err0_pulses", nerr, 1);
        chk("to_done0_pulses", ndone, 0);
        chk("to_err1_pulses", nerr1, 0);
        chk("to_busy", busy, 1'b0);
        chk("to_rdata", rdata, 32'hDEADBEEF);
        $display("txn timeout port0 mem_req_cycles=%0d err0_pulses=%0d", nreq, nerr);

        // Ack arrives in the 16th access cycle
        step();
        req0 = 1'b1; addr0 = 32'h300;
        sample();
        chk("lim_gnt0", gnt0, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 1) req0 = 1'b0;
            if (i == 16) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hCAFEF00D;
            end
            sample();
        end
        chk("lim_mem_req16", mem_req, 1'b1);
        step();
        mem_ack = 1'b0;
        sample();
        chk("lim_done0", done0, 1'b1);
        chk("lim_err0", err0, 1'b0);
        chk("lim_rdata", rdata, 32'hCAFEF00D);
        $display("txn ack_at_limit port0 rdata=%08h", rdata);

        // Reset during the second access cycle
        step();
        req0 = 1'b1; addr0 = 32'h400;
        sample();
        chk("mr_gnt0", gnt0, 1'b1);
        step();
        req0 = 1'b0;
        sample();
        step();
        rst = 1'b1;
        mem_ack = 1'b1;
        #1;
        chk("mr_mem_req_async", mem_req, 1'b0);
        chk("mr_busy_async", busy, 1'b0);
        sample();
        step();
        mem_ack = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("mr_no_pulse", {err0, done0}, 2'b00);
            step();
        end
        chk("mr_rdata", rdata, 32'h0);
        req0 = 1'b1; addr0 = 32'h500;
        sample();
        chk("mr_regrant", gnt0, 1'b1);
        step();
        req0 = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h600D;
        sample();
        chk("mr_mem_addr", mem_addr, 32'h500);
        step();
        mem_ack = 1'b0;
        sample();
        chk("mr_done0", done0, 1'b1);
        chk("mr_rdata2", rdata, 32'h600D);
        $display("txn reset_mid_access then read port0 rdata=%08h", rdata);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
